// File: rtl/mem_link_scheduler.sv
// Round-robin bus master that shares the serial memory link between
// NREQ requesters, one complete START/ADDR/ACK/DATA/ACK/STOP frame at a time.
//
// Ports:
//   CLK, RST     clock, asynchronous active-high reset
//   req          per-requester request level
//   rw           per-requester direction (1 = write), sent as address bit 0
//   addr         per-requester 7-bit address, requester k at [7k+6:7k]
//   wdata        per-requester write byte, requester k at [8k+7:8k]
//   gnt          one-hot grant, held for the whole frame
//   done         one-cycle completion pulse to the granted requester
//   err          pulses with done when the address byte was NACKed
//   rdata        byte from the last successful read
//   busy         high from grant through the end of STOP
//   SCL          serial clock, idle high
//   sda_oe       open-drain pull-low enable for SDA
//   sda_in       sampled SDA line level
module mem_link_scheduler #(
    parameter int NREQ    = 4,
    parameter int BIT_CYC = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   rw,
    input  logic [7*NREQ-1:0] addr,
    input  logic [8*NREQ-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              err,
    output logic [7:0]        rdata,
    output logic              busy,
    output logic              SCL,
    output logic              sda_oe,
    input  logic              sda_in
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW = $clog2(BIT_CYC);
    localparam logic [PW-1:0] PH_LAST = PW'(BIT_CYC - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(BIT_CYC / 2);

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_START, S_ADDR,
        S_ACK1, S_DATA, S_ACK2, S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ph_q, ph_d;
    logic [2:0]      bit_q, bit_d;
    logic [LW-1:0]   last_q, last_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            busy_q, busy_d;
    logic            scl_q, scl_d;
    logic            oe_q, oe_d;
    logic            rw_q, rw_d;
    logic [7:0]      abyte_q, abyte_d;
    logic [7:0]      wbyte_q, wbyte_d;
    logic            nack_q, nack_d;
    logic [7:0]      shr_q, shr_d;

    logic            ph_end;
    logic [PW-1:0]   ph_nxt;
    logic            found;
    int              win;
    int              idx;
    logic            fin;

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        rw_d    = rw_q;
        abyte_d = abyte_q;
        wbyte_d = wbyte_q;
        nack_d  = nack_q;
        shr_d   = shr_q;

        ph_end = (ph_q == PH_LAST);
        ph_nxt = ph_end ? '0 : ph_q + PW'(1);

        // Round-robin search starting just after the last winner
        found = 1'b0;
        win   = 0;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last_q) + i) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                ph_d = '0;
                if (|req) state_d = S_ARB;
            end
            S_ARB: begin
                ph_d  = '0;
                bit_d = '0;
                if (found) begin
                    state_d    = S_START;
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    last_d     = LW'(win);
                    rw_d       = rw[win];
                    abyte_d    = {addr[7*win +: 7], rw[win]};
                    wbyte_d    = wdata[8*win +: 8];
                    nack_d     = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                ph_d = ph_nxt;
                if (ph_end) begin
                    state_d = S_ADDR;
                    bit_d   = '0;
                end
            end
            S_ADDR: begin
                ph_d = ph_nxt;
                if (ph_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_ACK1;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_ACK1: begin
                ph_d = ph_nxt;
                if (ph_q == PH_HALF) nack_d = sda_in;
                if (ph_end) state_d = nack_q ? S_STOP : S_DATA;
            end
            S_DATA: begin
                ph_d = ph_nxt;
                if (ph_q == PH_HALF && !rw_q) shr_d[bit_q] = sda_in;
                if (ph_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_ACK2;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_ACK2: begin
                ph_d = ph_nxt;
                if (ph_end) state_d = S_STOP;
            end
            S_STOP: begin
                ph_d = ph_nxt;
                if (ph_end) begin
                    state_d = (|req) ? S_ARB : S_IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                ph_d    = '0;
            end
        endcase

        // Outputs are derived from the next state so they line up with it
        scl_d = 1'b1;
        oe_d  = 1'b0;
        unique case (state_d)
            S_START: oe_d = (ph_d >= PH_HALF);
            S_ADDR: begin
                scl_d = (ph_d >= PH_HALF);
                oe_d  = ~abyte_d[bit_d];
            end
            S_ACK1: scl_d = (ph_d >= PH_HALF);
            S_DATA: begin
                scl_d = (ph_d >= PH_HALF);
                oe_d  = rw_d & ~wbyte_d[bit_d];
            end
            S_ACK2: begin
                scl_d = (ph_d >= PH_HALF);
                oe_d  = ~rw_d;
            end
            S_STOP: begin
                scl_d = (ph_d >= PH_HALF);
                oe_d  = (ph_d != PH_LAST);
            end
            default: begin
                scl_d = 1'b1;
                oe_d  = 1'b0;
            end
        endcase

        // Last cycle of STOP carries the completion pulses
        fin     = (state_d == S_STOP) && (ph_d == PH_LAST);
        done_d  = fin ? gnt_q : '0;
        err_d   = fin & nack_q;
        rdata_d = (fin && !rw_q && !nack_q) ? shr_q : rdata_q;
        busy_d  = |gnt_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            bit_q   <= '0;
            last_q  <= LW'(NREQ - 1);
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= 8'h00;
            busy_q  <= 1'b0;
            scl_q   <= 1'b1;
            oe_q    <= 1'b0;
            rw_q    <= 1'b0;
            abyte_q <= 8'h00;
            wbyte_q <= 8'h00;
            nack_q  <= 1'b0;
            shr_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            scl_q   <= scl_d;
            oe_q    <= oe_d;
            rw_q    <= rw_d;
            abyte_q <= abyte_d;
            wbyte_q <= wbyte_d;
            nack_q  <= nack_d;
            shr_q   <= shr_d;
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign err    = err_q;
    assign rdata  = rdata_q;
    assign busy   = busy_q;
    assign SCL    = scl_q;
    assign sda_oe = oe_q;

endmodule

// File: tb/tb_mem_link_scheduler.sv
// Directed bench for mem_link_scheduler: table of single-frame transactions
// plus round-robin, back-to-back and mid-frame reset sequences.
module tb_mem_link_scheduler;

    logic        CLK;
    logic        RST;
    logic [3:0]  req;
    logic [3:0]  rw;
    logic [27:0] addr;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        err;
    logic [7:0]  rdata;
    logic        busy;
    logic        SCL;
    logic        sda_oe;
    logic        sda_in;

    mem_link_scheduler #(.NREQ(4), .BIT_CYC(4)) dut (
        .CLK(CLK), .RST(RST), .req(req), .rw(rw), .addr(addr),
        .wdata(wdata), .gnt(gnt), .done(done), .err(err),
        .rdata(rdata), .busy(busy), .SCL(SCL), .sda_oe(sda_oe),
        .sda_in(sda_in)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int         k;
        bit         wr;
        logic [6:0] a;
        logic [7:0] wd;
        bit         nack;
        logic [7:0] slv;
        bit         mut;
        logic [7:0] e_ab;
        logic [7:0] e_mb;
        int         e_len;
        bit         e_err;
        logic [7:0] e_rd;
        bit         e_ack2;
    } vec_t;

    vec_t tbl [6];

    int checks;
    int failures;

    logic [3:0] f_gnt, f_done;
    logic       f_err, f_ack2, f_busy0, f_busy1;
    logic [7:0] f_ab, f_mb, f_rd;
    int         f_len, f_wcnt, f_pat;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_gnt();
        f_wcnt = 0;
        do begin
            @(negedge CLK);
            f_wcnt++;
        end while (gnt == 4'b0 && f_wcnt < 50);
    endtask

    task automatic do_frame(input int k, input bit wr, input bit nack,
                            input logic [7:0] slv, input bit mut,
                            input bit drop);
        int b, ph, stopb;
        logic sb;
        wait_gnt();
        f_gnt = gnt; f_busy0 = busy; f_busy1 = 1'b0;
        f_ab = 8'h00; f_mb = 8'h00; f_ack2 = 1'b0; f_pat = 0;
        f_done = 4'b0; f_err = 1'b0; f_len = 0; f_rd = 8'hxx;
        stopb = nack ? 10 : 19;
        for (int cyc = 0; cyc < 100; cyc++) begin
            b  = cyc / 4;
            ph = cyc % 4;
            sb = 1'b1;
            if (b == 9) sb = nack;
            if (!wr && !nack && b >= 10 && b <= 17) sb = slv[b-10];
            sda_in = sb & ~sda_oe;
            if (mut && cyc == 2) begin
                addr[7*k +: 7]  = ~addr[7*k +: 7];
                wdata[8*k +: 8] = ~wdata[8*k +: 8];
            end
            if (gnt !== f_gnt) f_pat++;
            if (SCL !== ((b == 0) || (ph >= 2))) f_pat++;
            if (b == 0 && sda_oe !== (ph >= 2)) f_pat++;
            if (b == stopb && sda_oe !== (ph != 3)) f_pat++;
            if (ph == 2) begin
                if (b >= 1 && b <= 8) f_ab[b-1] = ~sda_oe;
                if (!nack && b >= 10 && b <= 17) f_mb[b-10] = ~sda_oe;
                if (b == 18) f_ack2 = sda_oe;
            end
            if (done != 4'b0) begin
                f_done  = done;
                f_err   = err;
                f_len   = cyc + 1;
                f_busy1 = busy;
                f_rd    = rdata;
                if (drop) req[k] = 1'b0;
                break;
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int order [5];
        int dcnt;
        checks   = 0;
        failures = 0;

        tbl[0] = '{0, 1'b1, 7'h2A, 8'hA5, 1'b0, 8'h00, 1'b0,
                   8'h55, 8'hA5, 80, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{2, 1'b0, 7'h11, 8'h00, 1'b0, 8'h3C, 1'b0,
                   8'h22, 8'hFF, 80, 1'b0, 8'h3C, 1'b1};
        tbl[2] = '{1, 1'b0, 7'h40, 8'h00, 1'b1, 8'h00, 1'b0,
                   8'h80, 8'h00, 44, 1'b1, 8'h3C, 1'b0};
        tbl[3] = '{3, 1'b1, 7'h7F, 8'h00, 1'b0, 8'h00, 1'b1,
                   8'hFF, 8'h00, 80, 1'b0, 8'h3C, 1'b0};
        tbl[4] = '{2, 1'b1, 7'h33, 8'h12, 1'b1, 8'h00, 1'b0,
                   8'h67, 8'h00, 44, 1'b1, 8'h3C, 1'b0};
        tbl[5] = '{0, 1'b0, 7'h05, 8'h00, 1'b0, 8'hC3, 1'b0,
                   8'h0A, 8'hFF, 80, 1'b0, 8'hC3, 1'b1};

        RST    = 1'b1;
        req    = 4'b0;
        rw     = 4'b0;
        addr   = '0;
        wdata  = '0;
        sda_in = 1'b1;
        repeat (2) @(negedge CLK);
        chk("reset_state", {SCL, sda_oe, gnt, done, err, busy, rdata},
            {1'b1, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 8'h00});
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        for (int i = 0; i < 6; i++) begin
            rw[tbl[i].k]            = tbl[i].wr;
            addr[7*tbl[i].k +: 7]   = tbl[i].a;
            wdata[8*tbl[i].k +: 8]  = tbl[i].wd;
            req[tbl[i].k]           = 1'b1;
            do_frame(tbl[i].k, tbl[i].wr, tbl[i].nack, tbl[i].slv,
                     tbl[i].mut, 1'b1);
            chk($sformatf("v%0d_gnt", i), f_gnt, 4'b1 << tbl[i].k);
            chk($sformatf("v%0d_latency", i), f_wcnt, 2);
            chk($sformatf("v%0d_done", i), f_done, 4'b1 << tbl[i].k);
            chk($sformatf("v%0d_err", i), f_err, tbl[i].e_err);
            chk($sformatf("v%0d_len", i), f_len, tbl[i].e_len);
            chk($sformatf("v%0d_addr_byte", i), f_ab, tbl[i].e_ab);
            chk($sformatf("v%0d_data_byte", i), f_mb, tbl[i].e_mb);
            chk($sformatf("v%0d_ack2_oe", i), f_ack2, tbl[i].e_ack2);
            chk($sformatf("v%0d_rdata", i), f_rd, tbl[i].e_rd);
            chk($sformatf("v%0d_bus_pattern", i), f_pat, 0);
            chk($sformatf("v%0d_busy", i), {f_busy0, f_busy1}, 2'b11);
            @(negedge CLK);
            chk($sformatf("v%0d_idle_after", i), {gnt, busy}, 5'b0);
            repeat (2) @(negedge CLK);
        end

        // Round robin with all requests held after a fresh reset
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        order = '{0, 1, 2, 3, 0};
        rw    = 4'hF;
        addr  = 28'h1234567;
        wdata = 32'h89ABCDEF;
        req   = 4'hF;
        for (int j = 0; j < 5; j++) begin
            do_frame(order[j], 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            chk($sformatf("rr%0d_gnt", j), f_gnt, 4'b1 << order[j]);
            chk($sformatf("rr%0d_gap", j), f_wcnt, 2);
            chk($sformatf("rr%0d_done", j), f_done, 4'b1 << order[j]);
        end
        req = 4'b0;
        repeat (4) @(negedge CLK);

        // Reset in the middle of DATA bit 4 of a write by requester 2
        sda_in         = 1'b0;
        rw[2]          = 1'b1;
        addr[14 +: 7]  = 7'h15;
        wdata[16 +: 8] = 8'h00;
        req            = 4'b0100;
        wait_gnt();
        chk("mr_gnt", gnt, 4'b0100);
        req = 4'b0;
        repeat (56) @(negedge CLK);
        chk("mr_pre_reset", {SCL, sda_oe, gnt}, {1'b0, 1'b1, 4'b0100});
        RST = 1'b1;
        #1;
        chk("mr_reset_now", {SCL, sda_oe, gnt, done, err, busy},
            {1'b1, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0});
        dcnt = 0;
        repeat (3) begin
            @(negedge CLK);
            if (done != 4'b0) dcnt++;
        end
        chk("mr_no_done", dcnt, 0);
        req = 4'b1010;
        RST = 1'b0;
        wait_gnt();
        chk("mr_regrant", gnt, 4'b0010);
        chk("mr_latency", f_wcnt, 2);
        req = 4'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_link_scheduler.md
# mem_link_scheduler

Bus-master scheduler that shares the serial memory link (SCL/SDA into the memory controller) between NREQ on-chip requesters. It round-robin arbitrates pending requests and serializes each one as a complete frame: START, address byte, ACK, data byte, ACK, STOP. It returns read data, a completion pulse and a NACK error to the granted requester. One transaction is in flight at a time.

## Interface
- NREQ, 4: number of requesters, 2..8
- BIT_CYC, 4: CLK cycles per serial bit time; even, >= 4
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester request level
- rw  in  NREQ  per-requester direction: 1 = write, 0 = read (sent as address-byte bit 0)
- addr  in  7*NREQ  per-requester 7-bit memory address, requester k at [7k+6:7k]
- wdata  in  8*NREQ  per-requester write byte, requester k at [8k+7:8k]
- gnt  out  NREQ  one-hot grant, high for the whole frame of the granted requester
- done  out  NREQ  one-cycle completion pulse to the granted requester
- err  out  1  one-cycle pulse coincident with done when the address ACK was a NACK
- rdata  out  8  read byte of the last completed read; holds until the next read completes
- busy  out  1  high from grant through end of STOP
- SCL  out  1  serial clock, idle high
- sda_oe  out  1  open-drain pull-low enable; 1 drives SDA to 0, 0 releases it (line reads 1)
- sda_in  in  1  sampled SDA line level

## Operation
- States: IDLE, ARB, START, ADDR, ACK1, DATA, ACK2, STOP.
- IDLE: SCL=1, sda_oe=0, gnt=0. Go to ARB when any req bit is high.
- ARB (1 cycle): search from (last+1) mod NREQ upward with wrap. The first requester with req high is granted: gnt set, and its rw, addr and wdata are latched. last is updated to the granted index. Go to START. If req has dropped to all zeros, return to IDLE.
- Latched values are used for the whole frame. req, rw, addr and wdata changes after ARB are ignored.
- START (1 bit time): SCL high throughout. SDA released for the first half, then pulled low for the second half.
- ADDR (8 bit times): shift out byte {addr, rw} LSB first, so bit 0 (rw) goes first and addr[6] goes last.
- ACK1 (1 bit time): SDA released. sda_in sampled at the SCL rising point. 0 = ACK, go to DATA. 1 = NACK, set error flag and go to STOP.
- DATA (8 bit times), LSB first:
  - write: shift out wdata.
  - read: SDA released; sda_in sampled into a shift register bit 0..7.
- ACK2 (1 bit time):
  - write: SDA released; the sampled value is ignored.
  - read: master pulls SDA low (ACK).
- STOP (1 bit time): SDA pulled low while SCL is low and at SCL rise. SDA released in the final cycle of the bit time.
- End of STOP cycle:
  - done[granted] pulses.
  - err pulses if the error flag is set.
  - rdata updates for a successful read (not on NACK).
  - gnt and busy drop.
  - Next state is ARB if any req is high, else IDLE.
- Requesters must deassert req on or before the cycle after done, or they are re-eligible in the next ARB.

## Timing
- Bit-phase counter ph runs 0..BIT_CYC-1 in every bit time.
- Outside START: SCL=0 for ph < BIT_CYC/2, SCL=1 otherwise.
- sda_oe changes only at ph==0, except in START and STOP, which change at ph==BIT_CYC/2 and ph==BIT_CYC-1 respectively.
- sda_in is sampled at ph==BIT_CYC/2, the SCL rising cycle.
- Frame length: START 1 + ADDR 8 + ACK1 1 + DATA 8 + ACK2 1 + STOP 1 = 20 bit times. With BIT_CYC=4 that is 80 cycles.
- NACK frame: 1 + 8 + 1 + 1 = 11 bit times.
- Latency: req high at cycle t (from IDLE) → ARB at t+1 → gnt high at t+2 → done in the last cycle of the frame.
- Back-to-back: after done, the next frame's gnt is asserted 2 cycles later (one ARB cycle, no IDLE cycle).
- Simultaneous requests: lowest index at or after last+1 wins. After reset last = NREQ-1, so requester 0 wins first.
- Reset values, asynchronous and effective immediately, including mid-frame:
  - state IDLE, SCL=1, sda_oe=0, gnt=0, done=0, err=0, busy=0, rdata=8'h00, last=NREQ-1.
  - A truncated frame produces no done.

## Test plan
- Write, req[0] with addr=7'h2A, wdata=8'hA5, bench slave ACKs → SDA bit sequence 1,0,1,0,1,0,1,0 (address byte 8'h55, LSB first), ACK, then 1,0,1,0,0,1,0,1 (8'hA5 LSB first); done[0] exactly 80 cycles after gnt[0] rises; err=0.
- Read, req[2] with addr=7'h11, slave drives 8'h3C → master releases SDA in DATA, pulls low in ACK2; rdata=8'h3C at done[2]; err=0.
- All four req high simultaneously and held → grants in order 0,1,2,3,0; each gnt one-hot; 2 cycles between each done and the next gnt.
- No slave ACK at ACK1 (sda_in=1) → no DATA phase; STOP follows ACK1; done and err pulse together 44 cycles after gnt; rdata unchanged.
- RST asserted at bit 4 of DATA → same cycle: SCL=1, sda_oe=0, gnt=0, no done; after release with req[1] high, requester 0 absent → gnt[1] first.
- Requester changes addr and wdata after grant → the transmitted frame carries the values latched at ARB.
